led_pwm_periph: RTL and testbench

LED_PWM_PERIPH -- requirements
Module: led_pwm_periph

---
 rtl/led_pwm_pkg.sv | 17 +
 rtl/led_pwm_timebase.sv | 52 +++++
 rtl/led_pwm_periph.sv | 102 ++++++++++
 tb/tb_led_pwm_periph.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: register map, CTRL bit positions, STATUS layout and byte-merge helper
package led_pwm_pkg;
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_DUTY     = 3'd2;
    localparam logic [2:0] OFF_BLINK    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int STATUS_CNT_W  = 8;
    localparam int STATUS_PHASE  = 8;
    function automatic logic [31:0] be_merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: prescaler, PWM counter and blink phase generator
//   clk_i, rst_i           : clock, synchronous active-high reset
//   i_en, i_blink_en       : CTRL.EN / CTRL.BLINK_EN
//   i_prescale, i_blink    : PRESCALE and BLINK register values
//   i_presc_clr, i_blink_clr : register write strobes, clear the matching counter
//   o_pwm_cnt, o_blink_phase : counter state for the LED compare and STATUS
module led_pwm_timebase #(
    parameter int DutyWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_en,
    input  logic                 i_blink_en,
    input  logic [15:0]          i_prescale,
    input  logic [15:0]          i_blink,
    input  logic                 i_presc_clr,
    input  logic                 i_blink_clr,
    output logic [DutyWidth-1:0] o_pwm_cnt,
    output logic                 o_blink_phase
);
    logic [15:0]          r_presc;
    logic [DutyWidth-1:0] r_pwm;
    logic [15:0]          r_blink_cnt;
    logic                 r_phase;
    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_toggle;
    // a register write wins over a coincident tick/wrap on the same edge
    assign w_tick   = (r_presc == i_prescale) & ~i_presc_clr;
    assign w_wrap   = w_tick & (r_pwm == '1);
    assign w_toggle = w_wrap & (r_blink_cnt == i_blink) & ~i_blink_clr;
    always_ff @(posedge clk_i) begin
        if (rst_i || !i_en) begin
            r_presc     <= '0;
            r_pwm       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else begin
            r_presc <= (i_presc_clr || w_tick) ? '0 : r_presc + 16'd1;
            r_pwm   <= r_pwm + DutyWidth'(w_tick);
            if (!i_blink_en) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b1;
            end else begin
                r_blink_cnt <= (i_blink_clr || w_toggle) ? '0 : r_blink_cnt + 16'(w_wrap);
                r_phase     <= r_phase ^ w_toggle;
            end
        end
    end
    assign o_pwm_cnt     = r_pwm;
    assign o_blink_phase = r_phase;
endmodule

// File: rtl/led_pwm_periph.sv
// led_pwm_periph: bus-attached PWM LED driver with prescaler and blink
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_i, we_i, be_i, addr_i, wdata_i : data-port request (addr bits [4:2] decoded)
//   gnt_o         : same-cycle grant
//   rvalid_o, err_o, rdata_o : registered response, one cycle after each request
//   led_o         : registered LED drive
module led_pwm_periph
    import led_pwm_pkg::*;
#(
    parameter int NumLeds   = 4,
    parameter int DutyWidth = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic               err_o,
    output logic [NumLeds-1:0] led_o
);
    localparam logic [31:0] DutyMask = 32'((64'd1 << (8 * NumLeds)) - 64'd1);
    logic [1:0]           r_ctrl;
    logic [15:0]          r_prescale;
    logic [15:0]          r_blink;
    logic [31:0]          r_duty;
    logic                 r_rvalid;
    logic                 r_err;
    logic [31:0]          r_rdata;
    logic [NumLeds-1:0]   r_led;
    logic [2:0]           w_off;
    logic                 w_bad;
    logic                 w_wr;
    logic [31:0]          w_rd;
    logic [31:0]          w_merged;
    logic [31:0]          w_status;
    logic [DutyWidth-1:0] w_pwm;
    logic                 w_phase;
    logic [NumLeds-1:0]   w_led;
    logic                 w_unused;
    assign w_unused = ^{addr_i[31:5], addr_i[1:0]};
    assign w_off    = addr_i[4:2];
    assign w_bad    = (w_off > OFF_STATUS) | (we_i & (w_off == OFF_STATUS));
    assign w_wr     = req_i & we_i & ~w_bad;
    assign gnt_o    = req_i;
    always_comb begin
        w_status = '0;
        w_status[STATUS_CNT_W-1:0] = STATUS_CNT_W'(w_pwm);
        w_status[STATUS_PHASE] = w_phase;
    end
    assign w_rd = (w_off == OFF_CTRL)     ? {30'b0, r_ctrl} :
                  (w_off == OFF_PRESCALE) ? {16'b0, r_prescale} :
                  (w_off == OFF_DUTY)     ? r_duty :
                  (w_off == OFF_BLINK)    ? {16'b0, r_blink} :
                  (w_off == OFF_STATUS)   ? w_status : '0;
    // writes merge onto the current readback so only enabled bytes change
    assign w_merged = be_merge(w_rd, wdata_i, be_i);
    led_pwm_timebase #(.DutyWidth(DutyWidth)) u_timebase (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_en         (r_ctrl[CTRL_EN]),
        .i_blink_en   (r_ctrl[CTRL_BLINK_EN]),
        .i_prescale   (r_prescale),
        .i_blink      (r_blink),
        .i_presc_clr  (w_wr && w_off == OFF_PRESCALE),
        .i_blink_clr  (w_wr && w_off == OFF_BLINK),
        .o_pwm_cnt    (w_pwm),
        .o_blink_phase(w_phase)
    );
    for (genvar i = 0; i < NumLeds; i++) begin : g_led
        assign w_led[i] = r_ctrl[CTRL_EN] & w_phase & (w_pwm < r_duty[8*i +: DutyWidth]);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_blink    <= '0;
            r_duty     <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_led      <= '0;
        end else begin
            r_rvalid <= req_i;
            r_err    <= req_i & w_bad;
            r_rdata  <= (req_i && !we_i && !w_bad) ? w_rd : '0;
            r_led    <= w_led;
            if (w_wr && w_off == OFF_CTRL)     r_ctrl     <= w_merged[1:0];
            if (w_wr && w_off == OFF_PRESCALE) r_prescale <= w_merged[15:0];
            if (w_wr && w_off == OFF_DUTY)     r_duty     <= w_merged & DutyMask;
            if (w_wr && w_off == OFF_BLINK)    r_blink    <= w_merged[15:0];
        end
    end
    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign rdata_o  = r_rdata;
    assign led_o    = r_led;
endmodule

// File: tb/tb_led_pwm_periph.sv
// tb_led_pwm_periph: closed-form timing model plus directed register/PWM/blink scenarios
module tb_led_pwm_periph;
    logic        clk, rst, req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic [3:0]  led;
    int n_cmp = 0;
    int n_bad = 0;
    // model: register contents and number of enabled edges since enabling
    logic [31:0] m_ctrl, m_p, m_b, m_duty;
    int          m_n;
    int          win_start, win_len;
    int          hist [2][4];
    led_pwm_periph dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err), .led_o(led)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic int m_pwm();
        return (m_n / (m_p + 1)) % 256;
    endfunction
    function automatic int m_phase();
        int wraps;
        wraps = m_n / ((m_p + 1) * 256);
        return m_ctrl[1] ? 1 ^ ((wraps / (m_b + 1)) & 1) : 1;
    endfunction
    function automatic logic [31:0] m_read(input int off);
        case (off)
            0: return m_ctrl;
            1: return m_p;
            2: return m_duty;
            3: return m_b;
            4: return (m_phase() << 8) | m_pwm();
            default: return 0;
        endcase
    endfunction
    task automatic cycle();
        logic [3:0]  e_led;
        logic        e_rv, e_err, bad;
        logic [31:0] e_rd, cur;
        int off, pre_n, bk;
        logic pre_en;
        off = int'(addr[4:2]);
        bad = (off > 4) || (we && off == 4);
        pre_n = m_n;
        pre_en = m_ctrl[0];
        for (int i = 0; i < 4; i++)
            e_led[i] = !rst && m_ctrl[0] && m_phase() == 1 && m_pwm() < int'((m_duty >> (8 * i)) & 32'hFF);
        e_rv  = !rst && req;
        e_err = !rst && req && bad;
        e_rd  = (!rst && req && !we && !bad) ? m_read(off) : 32'h0;
        #1;
        check("gnt", {31'b0, gnt}, {31'b0, req});
        @(posedge clk);
        #1;
        check("led", {28'b0, led}, {28'b0, e_led});
        check("rvalid", {31'b0, rvalid}, {31'b0, e_rv});
        check("err", {31'b0, err}, {31'b0, e_err});
        check("rdata", rdata, e_rd);
        if (!rst && pre_en && pre_n >= win_start && pre_n < win_start + 2 * win_len) begin
            bk = (pre_n - win_start) / win_len;
            for (int i = 0; i < 4; i++) hist[bk][i] += int'(led[i]);
        end
        if (rst) begin
            m_ctrl = 0; m_p = 0; m_b = 0; m_duty = 0; m_n = 0;
        end else begin
            m_n = pre_en ? m_n + 1 : 0;
            if (req && we && !bad) begin
                cur = m_read(off);
                for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
                case (off)
                    0: m_ctrl = cur & 32'h3;
                    1: m_p    = cur & 32'hFFFF;
                    2: m_duty = cur;
                    3: m_b    = cur & 32'hFFFF;
                    default: ;
                endcase
            end
        end
    endtask
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output logic rv);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        cycle();
        rd = rdata; e = err; rv = rvalid;
        req = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    endtask
    task automatic open_window(input int start, input int len);
        win_start = start;
        win_len = len;
        for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) hist[k][i] = 0;
    endtask
    task automatic run_to(input int target);
        for (int k = 0; k < 10000 && m_n < target; k++) cycle();
        check("run_to_reached", 32'(m_n), 32'(target));
    endtask
    logic [31:0] rd;
    logic        e, rv;
    initial begin
        m_ctrl = 0; m_p = 0; m_b = 0; m_duty = 0; m_n = 0;
        open_window(1 << 30, 1);
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) cycle();
        rst = 1'b0;
        check("reset_led", {28'b0, led}, 32'h0);
        check("reset_rvalid", {31'b0, rvalid}, 32'h0);
        bus(1'b0, 32'h00, 4'hF, 32'h0, rd, e, rv);
        check("ctrl_rvalid", {31'b0, rv}, 32'h1);
        check("ctrl_rdata", rd, 32'h0);
        check("ctrl_err", {31'b0, e}, 32'h0);
        cycle();
        check("idle_rvalid", {31'b0, rvalid}, 32'h0);
        bus(1'b1, 32'h08, 4'b0010, 32'hAABBCCDD, rd, e, rv);
        bus(1'b0, 32'h08, 4'hF, 32'h0, rd, e, rv);
        check("duty_be", rd, 32'h0000CC00);
        bus(1'b1, 32'h04, 4'hF, 32'hFFFFFFFF, rd, e, rv);
        bus(1'b0, 32'h04, 4'hF, 32'h0, rd, e, rv);
        check("prescale_mask", rd, 32'h0000FFFF);
        bus(1'b0, 32'h18, 4'hF, 32'h0, rd, e, rv);
        check("bad_rd_err", {31'b0, e}, 32'h1);
        check("bad_rd_data", rd, 32'h0);
        bus(1'b1, 32'h10, 4'hF, 32'hFFFFFFFF, rd, e, rv);
        check("status_wr_err", {31'b0, e}, 32'h1);
        bus(1'b1, 32'h1C, 4'hF, 32'h12345678, rd, e, rv);
        check("bad_wr_err", {31'b0, e}, 32'h1);
        bus(1'b0, 32'h10, 4'hF, 32'h0, rd, e, rv);
        check("status_unchanged", rd, 32'h00000100);
        bus(1'b0, 32'h08, 4'hF, 32'h0, rd, e, rv);
        check("duty_unchanged", rd, 32'h0000CC00);
        bus(1'b1, 32'h04, 4'hF, 32'h0, rd, e, rv);
        bus(1'b1, 32'h08, 4'hF, 32'h00FF4000, rd, e, rv);
        bus(1'b1, 32'h00, 4'hF, 32'h1, rd, e, rv);
        open_window(0, 256);
        run_to(300);
        check("pwm_led0_cnt", 32'(hist[0][0]), 32'd0);
        check("pwm_led1_cnt", 32'(hist[0][1]), 32'd64);
        check("pwm_led2_cnt", 32'(hist[0][2]), 32'd255);
        check("pwm_led3_cnt", 32'(hist[0][3]), 32'd0);
        bus(1'b1, 32'h08, 4'b0001, 32'h00000080, rd, e, rv);
        repeat (300) cycle();
        bus(1'b1, 32'h00, 4'hF, 32'h0, rd, e, rv);
        repeat (3) cycle();
        bus(1'b1, 32'h04, 4'hF, 32'h3, rd, e, rv);
        bus(1'b1, 32'h0C, 4'hF, 32'h1, rd, e, rv);
        bus(1'b1, 32'h08, 4'hF, 32'hFF, rd, e, rv);
        bus(1'b1, 32'h00, 4'hF, 32'h3, rd, e, rv);
        open_window(0, 2048);
        run_to(2100);
        bus(1'b0, 32'h10, 4'hF, 32'h0, rd, e, rv);
        check("status_phase0", rd, 32'h0000000D);
        run_to(4200);
        check("blink_led0_phase1", 32'(hist[0][0]), 32'd2040);
        check("blink_led0_phase0", 32'(hist[1][0]), 32'd0);
        check("led0_on_before_rst", {31'b0, led[0]}, 32'h1);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10;
        cycle();
        check("rst_led", {28'b0, led}, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        rst = 1'b0; req = 1'b0;
        cycle();
        check("rst_dropped", {31'b0, rvalid}, 32'h0);
        bus(1'b0, 32'h10, 4'hF, 32'h0, rd, e, rv);
        check("rst_status", rd, 32'h00000100);
        repeat (2) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
